// File: rtl/traffic_phase_arbiter.sv
// ============================================================================
// traffic_phase_arbiter: round-robin right-of-way arbiter with min/max green,
// all-red clearance and emergency preemption. Optional macro: TRAFFIC_ARB_HOLD_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module traffic_phase_arbiter #(
    parameter int MIN_GREEN  = 20,
    parameter int MAX_GREEN  = 60,
    parameter int CLEAR_TIME = 5,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       emergency,
    input  logic [1:0] emg_dir,
    output logic [3:0] grant,
    output logic       clearing,
    output logic       preempt_active,
    output logic [3:0] pending
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GREEN   = 2'd1,
        S_CLEAR   = 2'd2,
        S_PREEMPT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_MIN_M1 = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] C_MAX_M1 = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] C_CLR_M1 = CNT_W'(CLEAR_TIME - 1);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    if ((MAX_GREEN - 1 >= (1 << CNT_W)) || (MAX_GREEN < MIN_GREEN) || (CLEAR_TIME < 1))
    begin : g_param_check
        $error("traffic_phase_arbiter: illegal MIN/MAX_GREEN, CLEAR_TIME or CNT_W");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       grant_q, grant_d;
    logic [3:0]       pending_q, pending_d;
    logic             clearing_q, clearing_d;
    logic             preempt_q, preempt_d;

    logic [3:0] w_active;
    logic       w_any;
    logic       w_found;
    logic [1:0] w_win_idx;
    logic [1:0] w_idx;
    logic [1:0] w_grant_idx;
    logic [3:0] w_load;

    // Circular search starting just after the most recently served index.
    always_comb begin
        w_active  = pending_q | req;
        w_any     = |w_active;
        w_found   = 1'b0;
        w_win_idx = last_q;
        w_idx     = last_q;
        for (int i = 1; i <= 4; i++) begin
            w_idx = last_q + 2'(i);
            if (!w_found && w_active[w_idx]) begin
                w_win_idx = w_idx;
                w_found   = 1'b1;
            end
        end
    end

    always_comb begin
        case (grant_q)
            4'b0010: w_grant_idx = 2'd1;
            4'b0100: w_grant_idx = 2'd2;
            4'b1000: w_grant_idx = 2'd3;
            default: w_grant_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        last_d     = last_q;
        grant_d    = grant_q;
        clearing_d = clearing_q;
        preempt_d  = preempt_q;
        w_load     = 4'b0000;

        if (emergency) begin
            // Direction is captured only on entry; later emg_dir changes are ignored.
            if (state_q != S_PREEMPT) begin
                state_d    = S_PREEMPT;
                grant_d    = 4'b0001 << emg_dir;
                w_load     = 4'b0001 << emg_dir;
                preempt_d  = 1'b1;
                clearing_d = 1'b0;
                timer_d    = '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    grant_d = 4'b0000;
                    if (w_any) begin
                        state_d = S_GREEN;
                        grant_d = 4'b0001 << w_win_idx;
                        w_load  = 4'b0001 << w_win_idx;
                        timer_d = '0;
                        last_d  = w_win_idx;
                    end
                end
                S_GREEN: begin
                    if ((timer_q >= C_MIN_M1) && (|(w_active & ~grant_q))) begin
                        state_d    = S_CLEAR;
                        grant_d    = 4'b0000;
                        clearing_d = 1'b1;
                        timer_d    = '0;
                    end else if (timer_q == C_MAX_M1) begin
`ifdef TRAFFIC_ARB_HOLD_EN
                        timer_d    = C_MIN_M1;
`else
                        state_d    = S_CLEAR;
                        grant_d    = 4'b0000;
                        clearing_d = 1'b1;
                        timer_d    = '0;
`endif
                    end else begin
                        timer_d = timer_q + C_ONE;
                    end
                end
                S_CLEAR: begin
                    if (timer_q == C_CLR_M1) begin
                        clearing_d = 1'b0;
                        timer_d    = '0;
                        if (w_any) begin
                            state_d = S_GREEN;
                            grant_d = 4'b0001 << w_win_idx;
                            w_load  = 4'b0001 << w_win_idx;
                            last_d  = w_win_idx;
                        end else begin
                            state_d = S_IDLE;
                            grant_d = 4'b0000;
                        end
                    end else begin
                        timer_d = timer_q + C_ONE;
                    end
                end
                S_PREEMPT: begin
                    state_d    = S_CLEAR;
                    last_d     = w_grant_idx;
                    grant_d    = 4'b0000;
                    clearing_d = 1'b1;
                    preempt_d  = 1'b0;
                    timer_d    = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    grant_d = 4'b0000;
                end
            endcase
        end
    end

    assign pending_d = (pending_q | req) & ~w_load;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            last_q     <= 2'd3;
            grant_q    <= 4'b0000;
            pending_q  <= 4'b0000;
            clearing_q <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            pending_q  <= pending_d;
            clearing_q <= clearing_d;
            preempt_q  <= preempt_d;
        end
    end

    assign grant          = grant_q;
    assign clearing       = clearing_q;
    assign preempt_active = preempt_q;
    assign pending        = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_arbiter.sv
// ============================================================================
// tb_traffic_phase_arbiter: vector table, directed sequences and random
// stimulus compared against a cycle-level behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_traffic_phase_arbiter;

    localparam int MIN = 4;
    localparam int MAX = 8;
    localparam int CLR = 2;
`ifdef TRAFFIC_ARB_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       emergency = 1'b0;
    logic [1:0] emg_dir = 2'd0;
    logic [3:0] grant;
    logic       clearing;
    logic       preempt_active;
    logic [3:0] pending;

    traffic_phase_arbiter #(
        .MIN_GREEN  (MIN),
        .MAX_GREEN  (MAX),
        .CLEAR_TIME (CLR),
        .CNT_W      (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .emergency      (emergency),
        .emg_dir        (emg_dir),
        .grant          (grant),
        .clearing       (clearing),
        .preempt_active (preempt_active),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: which index holds the light (-1 none), how long it has been shown,
    // remaining all-red cycles, preemption flag and latched requests.
    int       m_grant = -1;
    int       m_age = 0;
    int       m_clear_left = 0;
    int       m_last = 3;
    bit       m_pre = 1'b0;
    bit [3:0] m_pend = 4'b0000;

    function automatic void model_step();
        bit [3:0] act;
        bit [3:0] mine;
        int       load;
        int       win;
        act  = m_pend | req;
        load = -1;
        win  = -1;
        for (int i = 1; i <= 4; i++) begin
            int j;
            j = (m_last + i) % 4;
            if (win < 0 && act[j]) win = j;
        end
        if (!reset) begin
            m_grant = -1; m_age = 0; m_clear_left = 0; m_last = 3;
            m_pre = 1'b0; m_pend = 4'b0000;
            return;
        end
        if (emergency) begin
            if (!m_pre) begin
                m_pre = 1'b1; m_grant = int'(emg_dir); m_clear_left = 0;
                load = int'(emg_dir);
            end
        end else if (m_pre) begin
            m_pre = 1'b0; m_last = m_grant; m_grant = -1; m_clear_left = CLR;
        end else if (m_clear_left > 0) begin
            m_clear_left--;
            if (m_clear_left == 0 && win >= 0) begin
                m_grant = win; m_age = 1; m_last = win; load = win;
            end
        end else if (m_grant >= 0) begin
            mine = 4'b0001 << m_grant;
            if ((m_age >= MIN && |(act & ~mine)) || (!HOLD && m_age >= MAX)) begin
                m_grant = -1; m_clear_left = CLR;
            end else begin
                m_age++;
            end
        end else if (win >= 0) begin
            m_grant = win; m_age = 1; m_last = win; load = win;
        end
        for (int i = 0; i < 4; i++) m_pend[i] = act[i] && (i != load);
    endfunction

    task automatic step(input bit r, input logic [3:0] q, input bit e, input logic [1:0] d);
        logic [3:0] eg;
        @(negedge clk);
        reset = r; req = q; emergency = e; emg_dir = d;
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        eg = (m_grant >= 0) ? (4'b0001 << m_grant) : 4'b0000;
        checks++;
        if (grant !== eg || clearing !== (m_clear_left > 0) || preempt_active !== m_pre
            || pending !== m_pend) begin
            errors++;
            $display("FAIL model cyc=%0d got g=%b c=%b p=%b pd=%b want g=%b c=%b p=%b pd=%b",
                     cyc, grant, clearing, preempt_active, pending,
                     eg, (m_clear_left > 0), m_pre, m_pend);
        end
    endtask

    task automatic expect_gc(input string name, input logic [3:0] g, input bit c);
        checks++;
        if (grant !== g || clearing !== c) begin
            errors++;
            $display("FAIL %s cyc=%0d got g=%b c=%b want g=%b c=%b", name, cyc, grant, clearing, g, c);
        end
    endtask

    typedef struct {
        bit         r;
        logic [3:0] q;
        bit         e;
        logic [1:0] d;
        logic [3:0] g;
        bit         c;
        bit         p;
        logic [3:0] pd;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [3:0] eg;
        bit         emg_on;
        bit         rr;
        logic [3:0] rq;

        tbl.push_back('{1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b0011, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b0, 4'b0010});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b0, 4'b0010});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b0, 4'b0010});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b0, 4'b0010});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 4'b0010});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 4'b0010});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 2'd0, 4'b0010, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 2'd0, 4'b0010, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b1, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 1'b1, 2'd0, 4'b0100, 1'b0, 1'b1, 4'b0000});
        tbl.push_back('{1'b1, 4'b0001, 1'b1, 2'd3, 4'b0100, 1'b0, 1'b1, 4'b0001});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 4'b0001});
        tbl.push_back('{1'b1, 4'b1000, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 4'b1001});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 2'd0, 4'b1000, 1'b0, 1'b0, 4'b0001});
        tbl.push_back('{1'b1, 4'b0000, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b1, 4'b0001});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b1010, 1'b0, 2'd0, 4'b0010, 1'b0, 1'b0, 4'b1000});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 4'b0000});

        foreach (tbl[k]) begin
            step(tbl[k].r, tbl[k].q, tbl[k].e, tbl[k].d);
            checks++;
            if (grant !== tbl[k].g || clearing !== tbl[k].c || preempt_active !== tbl[k].p
                || pending !== tbl[k].pd) begin
                errors++;
                $display("FAIL vec%0d got g=%b c=%b p=%b pd=%b want g=%b c=%b p=%b pd=%b",
                         k, grant, clearing, preempt_active, pending,
                         tbl[k].g, tbl[k].c, tbl[k].p, tbl[k].pd);
            end
        end

        // All four requesting continuously: 4 green, 2 clear, rotating 0..3.
        step(1'b0, 4'b0000, 1'b0, 2'd0);
        for (int k = 1; k <= 60; k++) begin
            step(1'b1, 4'b1111, 1'b0, 2'd0);
            eg = (((k - 1) % 6) < 4) ? (4'b0001 << (((k - 1) / 6) % 4)) : 4'b0000;
            expect_gc("rr_all", eg, (((k - 1) % 6) >= 4));
        end

        step(1'b0, 4'b0000, 1'b0, 2'd0);
`ifndef TRAFFIC_ARB_HOLD_EN
        // Lone pulse: max green then clearance then idle.
        step(1'b1, 4'b0001, 1'b0, 2'd0);
        expect_gc("pulse", 4'b0001, 1'b0);
        for (int k = 2; k <= 12; k++) begin
            step(1'b1, 4'b0000, 1'b0, 2'd0);
            if (k <= 8)       expect_gc("pulse_green", 4'b0001, 1'b0);
            else if (k <= 10) expect_gc("pulse_clear", 4'b0000, 1'b1);
            else              expect_gc("pulse_idle", 4'b0000, 1'b0);
        end
`else
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 4'b0010, 1'b0, 2'd0);
            expect_gc("hold_green", 4'b0010, 1'b0);
        end
        step(1'b1, 4'b0011, 1'b0, 2'd0);
        expect_gc("hold_end", 4'b0000, 1'b1);
        step(1'b1, 4'b0010, 1'b0, 2'd0);
        expect_gc("hold_clear", 4'b0000, 1'b1);
        step(1'b1, 4'b0010, 1'b0, 2'd0);
        expect_gc("hold_next", 4'b0001, 1'b0);
`endif

        emg_on = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (!emg_on && $urandom_range(0, 39) == 0) emg_on = 1'b1;
            else if (emg_on && $urandom_range(0, 7) == 0) emg_on = 1'b0;
            rr = ($urandom_range(0, 249) != 0);
            rq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            step(rr, rq, emg_on, 2'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
